yc_config_loader: RTL

//  Upstream driver for the ycconfig shift chain. Accepts 3-bit cell codes over a valid/ready handshake, buffers them,
//  and serialises each code MSB-first onto cbitout with a generated confclk.

---
 rtl/morphle_cfg_pkg.sv | 24 ++
 rtl/yc_cfg_fifo.sv | 48 ++++
 rtl/yc_config_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/morphle_cfg_pkg.sv
// Shared definitions for the ycconfig chain loader: cell code values and shifter states.
package morphle_cfg_pkg;

    typedef logic [2:0] cfg_code_t;

    localparam cfg_code_t CFG_SPACE = 3'b000;
    localparam cfg_code_t CFG_PLUS  = 3'b001;
    localparam cfg_code_t CFG_MINUS = 3'b010;
    localparam cfg_code_t CFG_VBAR  = 3'b011;
    localparam cfg_code_t CFG_ONE   = 3'b100;
    localparam cfg_code_t CFG_ZERO  = 3'b101;
    localparam cfg_code_t CFG_Y     = 3'b110;
    localparam cfg_code_t CFG_N     = 3'b111;

    localparam int CODE_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } cfg_state_t;

endpackage

// File: rtl/yc_cfg_fifo.sv
// Small code buffer between the push handshake and the serialiser; full/empty come
// straight from registered pointers so neither depends on this cycle's push or pop.
module yc_cfg_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/yc_config_loader.sv
// Serialises buffered 3-bit cell codes MSB-first onto cbitout/confclk for a ycconfig chain.
// Optional MORPHLE_CFG_READBACK_EN captures the codes falling off the chain tail via cbitret.
module yc_config_loader
    import morphle_cfg_pkg::*;
#(
    parameter int PHASE     = 2,
    parameter int FIFO_DEP  = 4,
    parameter int CHAIN_LEN = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [2:0]                     in_code,
    output logic                           confclk,
    output logic                           cbitout,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CHAIN_LEN+1)-1:0] cell_cnt,
    input  logic                           cbitret,
    output logic                           rb_valid,
    output logic [2:0]                     rb_code
);

    localparam int PW = (PHASE > 1) ? $clog2(PHASE) : 1;
    localparam int CW = $clog2(CHAIN_LEN+1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE - 1);
    localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    cfg_state_t  state;
    cfg_state_t  state_d;
    logic [PW-1:0] phase_cnt;
    logic [1:0]  idx;
    logic [2:0]  sreg;
    logic [2:0]  head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        phase_last;
    logic        pop;
    logic        load;
    logic        adv_bit;
    logic        cell_done;

    yc_cfg_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEP)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .pop   (pop),
        .wdata (in_code),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready   = !fifo_full;
    assign busy       = (state != IDLE) || !fifo_empty;
    assign phase_last = (phase_cnt == PHASE_LAST);

    always_comb begin
        state_d   = state;
        pop       = 1'b0;
        load      = 1'b0;
        adv_bit   = 1'b0;
        cell_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (phase_last) state_d = HIGH;
            end
            HIGH: begin
                if (phase_last) state_d = LOW;
            end
            LOW: begin
                if (phase_last) begin
                    if (idx != 2'd0) begin
                        adv_bit = 1'b1;
                        state_d = SETUP;
                    end else begin
                        // Chain straight into the next cell so back-to-back codes see no IDLE gap.
                        cell_done = 1'b1;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            load    = 1'b1;
                            state_d = SETUP;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // confclk and cbitout are registered from the next state, so the data bit settles
    // at SETUP entry and cannot move while the clock is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_cnt <= '0;
            idx       <= 2'd0;
            confclk   <= 1'b0;
            cbitout   <= 1'b0;
            cell_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            confclk <= (state_d == HIGH);
            done    <= 1'b0;
            if ((state_d != state) || (state_d == IDLE)) phase_cnt <= '0;
            else                                       phase_cnt <= phase_cnt + PHASE_ONE;
            if (load) begin
                idx     <= 2'd2;
                cbitout <= head[2];
            end else if (adv_bit) begin
                idx     <= idx - 2'd1;
                cbitout <= sreg[1];
            end
            if (cell_done) begin
                if (cell_cnt == CNT_LAST) begin
                    cell_cnt <= '0;
                    done     <= 1'b1;
                end else begin
                    cell_cnt <= cell_cnt + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load)         sreg <= head;
        else if (adv_bit) sreg <= {sreg[1:0], 1'b0};
    end

`ifdef MORPHLE_CFG_READBACK_EN
    logic [2:0] capture;
    logic       conf_rise;

    // Sample the tail on the edge that raises confclk, before the chain shifts.
    assign conf_rise = (state_d == HIGH) && (state != HIGH);

    always_ff @(posedge clk) begin
        if (conf_rise) capture <= {capture[1:0], cbitret};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rb_valid <= 1'b0;
            rb_code  <= 3'b000;
        end else begin
            rb_valid <= cell_done;
            if (cell_done) rb_code <= capture;
        end
    end
`else
    logic unused_cbitret;

    assign unused_cbitret = cbitret;
    assign rb_valid       = 1'b0;
    assign rb_code        = 3'b000;
`endif

endmodule
